// File: rtl/pio_host_sequencer.sv
// pio_host_sequencer: host-side command sequencer for the pio block.
// Loads a program image (INSTR), replays a configuration descriptor list verbatim,
// then pumps data: TX stream -> PUSH and PULL -> RX stream, shared round-robin
// over NUM_SM machines. On stop it disables every machine with EN 0.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, stop            control pulses
//   prog_len/addr/data     program source (1-cycle read latency)
//   cfg_addr/data          descriptor source {mindex, action, data} (1-cycle latency)
//   action/index/mindex/din  pio command port (one command per cycle)
//   dout, full, empty      pio RX data and per-machine FIFO flags
//   tx_*                   TX stream in (valid/ready)
//   rx_*                   RX stream out (valid/ready holding register)
//   busy, done, err        status: not idle, entered RUN, descriptor overrun
module pio_host_sequencer #(
    parameter int unsigned NUM_SM    = 4,
    parameter int unsigned CFG_DEPTH = 64,
    parameter int unsigned RX_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic [5:0]                   prog_len,
    output logic [4:0]                   prog_addr,
    input  logic [15:0]                  prog_data,
    output logic [$clog2(CFG_DEPTH)-1:0] cfg_addr,
    input  logic [37:0]                  cfg_data,
    output logic [3:0]                   action,
    output logic [4:0]                   index,
    output logic [1:0]                   mindex,
    output logic [31:0]                  din,
    input  logic [31:0]                  dout,
    input  logic [3:0]                   full,
    input  logic [3:0]                   empty,
    input  logic                         tx_valid,
    input  logic [1:0]                   tx_sm,
    input  logic [31:0]                  tx_data,
    output logic                         tx_ready,
    output logic                         rx_valid,
    output logic [1:0]                   rx_sm,
    output logic [31:0]                  rx_data,
    input  logic                         rx_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned CfgAw = $clog2(CFG_DEPTH);
    localparam logic [CfgAw-1:0] CfgLast = CfgAw'(CFG_DEPTH - 1);
    localparam logic [1:0] SmLast = 2'(NUM_SM - 1);

    localparam logic [3:0] ActNone  = 4'd0;
    localparam logic [3:0] ActInstr = 4'd1;
    localparam logic [3:0] ActPull  = 4'd3;
    localparam logic [3:0] ActPush  = 4'd4;
    localparam logic [3:0] ActEn    = 4'd6;

    typedef enum logic [2:0] {StIdle, StLoadProg, StLoadCfg, StRun, StDisable} state_e;

    state_e            state_q, state_d;
    logic [5:0]        len_q, len_d;
    logic [5:0]        paddr_q, paddr_d;
    logic              pv_q, pv_d;          // program word arriving this cycle
    logic [4:0]        pidx_q, pidx_d;
    logic [CfgAw-1:0]  caddr_q, caddr_d;
    logic              cdone_q, cdone_d;    // last descriptor address already fetched
    logic              cv_q, cv_d;          // descriptor arriving this cycle
    logic              clast_q, clast_d;    // ... and it is the final address
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [RX_LAT-1:0] pipe_q, pipe_d;      // PULL in flight, MSB = dout valid now
    logic [1:0]        pull_sm_q, pull_sm_d;
    logic [1:0]        last_q, last_d;
    logic [3:0]        blk_q, blk_d;
    logic              pri_rx_q, pri_rx_d;
    logic              stop_pend_q, stop_pend_d;
    logic [1:0]        dis_q, dis_d;
    logic              rx_valid_q, rx_valid_d;
    logic [1:0]        rx_sm_q, rx_sm_d;
    logic [31:0]       rx_data_q, rx_data_d;

    logic       tx_elig, rx_elig, rx_found, grant_tx, grant_rx;
    logic [1:0] rx_m, cand;

    // Eligibility. The scan wraps modulo 4; machines >= NUM_SM are skipped, which
    // keeps round-robin order among the real machines.
    always_comb begin
        tx_elig  = tx_valid && !full[tx_sm] && (32'(tx_sm) < NUM_SM) && !blk_q[tx_sm];
        rx_found = 1'b0;
        rx_m     = 2'd0;
        cand     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!rx_found && !empty[cand] && !blk_q[cand] && (32'(cand) < NUM_SM)) begin
                rx_found = 1'b1;
                rx_m     = cand;
            end
        end
        rx_elig = (pipe_q == '0) && (!rx_valid_q || rx_ready) && rx_found;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        paddr_d     = paddr_q;
        pv_d        = 1'b0;
        pidx_d      = pidx_q;
        caddr_d     = caddr_q;
        cdone_d     = cdone_q;
        cv_d        = 1'b0;
        clast_d     = clast_q;
        err_d       = err_q;
        done_d      = 1'b0;
        pull_sm_d   = pull_sm_q;
        last_d      = last_q;
        blk_d       = 4'd0;
        pri_rx_d    = pri_rx_q;
        stop_pend_d = stop_pend_q;
        dis_d       = dis_q;
        action      = ActNone;
        index       = 5'd0;
        mindex      = 2'd0;
        din         = 32'd0;
        tx_ready    = 1'b0;
        grant_tx    = 1'b0;
        grant_rx    = 1'b0;

        // The last program word lands in the first LOAD_CFG cycle, so issue it
        // independently of the current state.
        if (pv_q) begin
            action = ActInstr;
            index  = pidx_q;
            din    = {16'h0000, prog_data};
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d   = 1'b0;
                    len_d   = prog_len;
                    paddr_d = 6'd0;
                    caddr_d = '0;
                    cdone_d = 1'b0;
                    state_d = (prog_len == 6'd0) ? StLoadCfg : StLoadProg;
                end
            end
            StLoadProg: begin
                pv_d    = 1'b1;
                pidx_d  = paddr_q[4:0];
                paddr_d = paddr_q + 6'd1;
                if (paddr_q == len_q - 6'd1) state_d = StLoadCfg;
            end
            StLoadCfg: begin
                cv_d    = !cdone_q;
                clast_d = (caddr_q == CfgLast);
                if (!cdone_q) begin
                    if (caddr_q == CfgLast) cdone_d = 1'b1;
                    else                    caddr_d = caddr_q + 1'b1;
                end
                if (cv_q) begin
                    if (cfg_data[35:32] == ActNone) begin
                        // Terminator: not issued; discard the speculative fetch.
                        cv_d        = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StRun;
                        pri_rx_d    = 1'b0;
                        last_d      = SmLast;
                        stop_pend_d = 1'b0;
                    end else begin
                        action = cfg_data[35:32];
                        mindex = cfg_data[37:36];
                        din    = cfg_data[31:0];
                        if (clast_q) begin
                            cv_d    = 1'b0;
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            StRun: begin
                if (stop || stop_pend_q) begin
                    stop_pend_d = 1'b1;
                    if (pipe_q == '0) begin
                        stop_pend_d = 1'b0;
                        dis_d       = 2'd0;
                        state_d     = StDisable;
                    end
                end else begin
                    grant_tx = tx_elig && (!rx_elig || !pri_rx_q);
                    grant_rx = rx_elig && !grant_tx;
                    if (grant_tx) begin
                        action   = ActPush;
                        mindex   = tx_sm;
                        din      = tx_data;
                        tx_ready = 1'b1;
                        blk_d    = 4'b0001 << tx_sm;
                        pri_rx_d = 1'b1;
                    end else if (grant_rx) begin
                        action    = ActPull;
                        mindex    = rx_m;
                        blk_d     = 4'b0001 << rx_m;
                        pull_sm_d = rx_m;
                        last_d    = rx_m;
                        pri_rx_d  = 1'b0;
                    end
                end
            end
            StDisable: begin
                action = ActEn;
                mindex = dis_q;
                dis_d  = dis_q + 2'd1;
                if (dis_q == SmLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pipe_d     = (pipe_q << 1) | RX_LAT'(grant_rx);
        rx_valid_d = rx_valid_q;
        rx_sm_d    = rx_sm_q;
        rx_data_d  = rx_data_q;
        if (pipe_q[RX_LAT-1]) begin
            rx_valid_d = 1'b1;
            rx_sm_d    = pull_sm_q;
            rx_data_d  = dout;
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= 6'd0;
            paddr_q     <= 6'd0;
            pv_q        <= 1'b0;
            pidx_q      <= 5'd0;
            caddr_q     <= '0;
            cdone_q     <= 1'b0;
            cv_q        <= 1'b0;
            clast_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            pipe_q      <= '0;
            pull_sm_q   <= 2'd0;
            last_q      <= SmLast;
            blk_q       <= 4'd0;
            pri_rx_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            dis_q       <= 2'd0;
            rx_valid_q  <= 1'b0;
            rx_sm_q     <= 2'd0;
            rx_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            paddr_q     <= paddr_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
            caddr_q     <= caddr_d;
            cdone_q     <= cdone_d;
            cv_q        <= cv_d;
            clast_q     <= clast_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pipe_q      <= pipe_d;
            pull_sm_q   <= pull_sm_d;
            last_q      <= last_d;
            blk_q       <= blk_d;
            pri_rx_q    <= pri_rx_d;
            stop_pend_q <= stop_pend_d;
            dis_q       <= dis_d;
            rx_valid_q  <= rx_valid_d;
            rx_sm_q     <= rx_sm_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign prog_addr = paddr_q[4:0];
    assign cfg_addr  = caddr_q;
    assign rx_valid  = rx_valid_q;
    assign rx_sm     = rx_sm_q;
    assign rx_data   = rx_data_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pio_host_sequencer.sv
// Directed bench for pio_host_sequencer (NUM_SM=4, CFG_DEPTH=64, RX_LAT=1).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pio_host_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [5:0]  prog_len;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [5:0]  cfg_addr;
    logic [37:0] cfg_data;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic        tx_valid;
    logic [1:0]  tx_sm;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [1:0]  rx_sm;
    logic [31:0] rx_data;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] prog_mem [32];
    logic [37:0] cfg_mem  [64];

    int checks = 0;
    int errors = 0;

    pio_host_sequencer #(
        .NUM_SM   (4),
        .CFG_DEPTH(64),
        .RX_LAT   (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .prog_len (prog_len),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .action   (action),
        .index    (index),
        .mindex   (mindex),
        .din      (din),
        .dout     (dout),
        .full     (full),
        .empty    (empty),
        .tx_valid (tx_valid),
        .tx_sm    (tx_sm),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_sm    (rx_sm),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        prog_data <= prog_mem[prog_addr];
        cfg_data  <= cfg_mem[cfg_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unterminated descriptor: action 8, mindex k mod 4, data tagged with k.
    function automatic logic [37:0] fill_desc(input int k);
        return {2'(k), 4'd8, 32'h1000_0000 | 32'(k)};
    endfunction

    logic [37:0] t2 [5];
    int          ncmd;

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; prog_len = 6'd0;
        full = 4'h0; empty = 4'hF; tx_valid = 1'b0; tx_sm = 2'd0; tx_data = 32'd0;
        dout = 32'd0; rx_ready = 1'b0;
        for (int i = 0; i < 32; i++) prog_mem[i] = 16'hFFFF;
        prog_mem[0] = 16'h6001;
        prog_mem[1] = 16'h0000;
        // PEND 1, DIV 0x0C80, GRPS 0x20100001, EN 1, terminator (opaque codes 7/8/9).
        t2[0] = {2'd0, 4'd7, 32'h0000_0001};
        t2[1] = {2'd1, 4'd8, 32'h0000_0C80};
        t2[2] = {2'd2, 4'd9, 32'h2010_0001};
        t2[3] = {2'd0, 4'd6, 32'h0000_0001};
        t2[4] = {2'd3, 4'd0, 32'hDEAD_BEEF};
        for (int i = 0; i < 64; i++) cfg_mem[i] = fill_desc(i);
        for (int i = 0; i < 5; i++) cfg_mem[i] = t2[i];

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_action", 64'(action), 64'd0);
        chk("rst_idx_m_din", {25'd0, index, mindex, din}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_tx_ready", 64'(tx_ready), 64'd0);

        // T1: program load
        @(negedge clk); start = 1'b1; prog_len = 6'd2; #1;
        chk("t1_idle_busy", 64'(busy), 64'd0);
        @(negedge clk); start = 1'b0; #1;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_addr0", 64'(prog_addr), 64'd0);
        chk("t1_fetch_nocmd", 64'(action), 64'd0);
        @(negedge clk); #1;
        chk("t1_instr0", {action, index, din}, {4'd1, 5'd0, 32'h0000_6001});
        chk("t1_addr1", 64'(prog_addr), 64'd1);
        @(negedge clk); #1;
        chk("t1_instr1", {action, index, din}, {4'd1, 5'd1, 32'h0000_0000});

        // T2: descriptor replay
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("t2_desc", {mindex, action, din}, t2[k]);
        end
        @(negedge clk); #1;
        chk("t2_term_not_issued", 64'(action), 64'd0);
        chk("t2_done_early", 64'(done), 64'd0);
        @(negedge clk); #1;
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_run_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        chk("t2_done_pulse", 64'(done), 64'd0);

        // T3: PUSH, then sm0 blocked for one cycle
        tx_valid = 1'b1; tx_sm = 2'd0; tx_data = 32'h4000_0000; #1;
        chk("t3_push", {action, mindex, din}, {4'd4, 2'd0, 32'h4000_0000});
        chk("t3_tx_ready", 64'(tx_ready), 64'd1);
        @(negedge clk); tx_data = 32'h4000_0001; #1;
        chk("t3_blocked_cmd", 64'(action), 64'd0);
        chk("t3_blocked_ready", 64'(tx_ready), 64'd0);

        // T4: PULL sm0, capture, hold, then PULL sm2 on pop
        @(negedge clk); tx_valid = 1'b0; empty = 4'b1010; dout = 32'h11; #1;
        chk("t4_pull0", {action, mindex}, {4'd3, 2'd0});
        @(negedge clk); dout = 32'hA5; #1;
        chk("t4_outstanding", 64'(action), 64'd0);
        chk("t4_rx_not_yet", 64'(rx_valid), 64'd0);
        @(negedge clk); dout = 32'h22; #1;
        chk("t4_rx_word", {rx_valid, rx_sm, rx_data}, {1'b1, 2'd0, 32'hA5});
        chk("t4_full_hold_cmd", 64'(action), 64'd0);
        @(negedge clk); #1;
        chk("t4_rx_hold", {rx_valid, rx_sm, rx_data}, {1'b1, 2'd0, 32'hA5});
        chk("t4_no_pull_held", 64'(action), 64'd0);
        rx_ready = 1'b1; #1;
        chk("t4_pull2", {action, mindex}, {4'd3, 2'd2});

        // T6: stop while PULL outstanding
        @(negedge clk); rx_ready = 1'b0; stop = 1'b1; dout = 32'h5A; #1;
        chk("t6_popped", 64'(rx_valid), 64'd0);
        chk("t6_stop_nocmd", 64'(action), 64'd0);
        @(negedge clk); stop = 1'b0; #1;
        chk("t6_landed", {rx_valid, rx_sm, rx_data}, {1'b1, 2'd2, 32'h5A});
        chk("t6_drain_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("t6_en0", {action, mindex, din}, {4'd6, 2'(k), 32'd0});
        end
        @(negedge clk); #1;
        chk("t6_idle_busy", 64'(busy), 64'd0);
        chk("t6_idle_cmd", 64'(action), 64'd0);
        chk("t6_rx_kept", {rx_valid, rx_data}, {1'b1, 32'h5A});

        // T5: no terminator anywhere
        for (int i = 0; i < 64; i++) cfg_mem[i] = fill_desc(i);
        start = 1'b1; prog_len = 6'd0;
        @(negedge clk); start = 1'b0; #1;
        chk("t5_first_nocmd", 64'(action), 64'd0);
        ncmd = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk); #1;
            if (action != 4'd0) begin
                chk("t5_desc", {mindex, action, din}, fill_desc(ncmd));
                ncmd++;
            end
        end
        chk("t5_count", 64'(ncmd), 64'd64);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);

        // Restart clears err; then reset in the middle of LOAD_CFG
        start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("t5_err_cleared", 64'(err), 64'd0);
        chk("t5_restart_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        chk("t6_cfg_issue", {mindex, action, din}, fill_desc(0));
        @(negedge clk); reset = 1'b1; #1;
        chk("t6_cfg_issue1", {mindex, action, din}, fill_desc(1));
        @(negedge clk); #1;
        chk("t6_rst_action", 64'(action), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_rx", 64'(rx_valid), 64'd0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
